wrapper_arbiter: RTL

Round-robin scheduler that shares one exponential `wrapper` datapath among NREQ requesters. It captures a winner's `ui`/`vi` operands, starts the wrapper, and tags each result written toward the result FIFO with the requester ID. It signals job completion back to the winner. It issues a job only when the FIFO has room for the whole job, because the wrapper cannot stall once started.

---
 rtl/wrapper_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wrapper_arbiter.sv
// Round-robin front end for one shared exponential wrapper: grants a requester,
// launches the wrapper with its operands and tags every result with the requester id.
//
// state   | meaning
// S_IDLE  | waiting for a request and enough FIFO room for a whole job
// S_START | ack and w_start pulse, operands already stable on w_ui/w_vi
// S_RUN   | wrapper running; results forwarded and counted until w_done
module wrapper_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int RPJ    = 4,
  parameter int FREE_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   ui_in,
  input  logic [16*NREQ-1:0]  vi_in,
  output logic [NREQ-1:0]     ack,
  output logic [NREQ-1:0]     fin,
  input  logic [FREE_W-1:0]   fifo_free,
  output logic                w_start,
  output logic [1:0]          w_ui,
  output logic [15:0]         w_vi,
  input  logic                w_done,
  input  logic                w_wrdata,
  input  logic [20:0]         w_data,
  output logic                f_wr,
  output logic [21+IDW-1:0]   f_data,
  output logic                busy,
  output logic                err
);

  localparam int CNTW = $clog2(RPJ + 2);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  r_id;
  logic [CNTW-1:0] r_cnt;

  logic [IDW-1:0]  w_win;
  logic            w_found;
  logic            w_issue;
  logic [CNTW-1:0] w_cnt_next;

  // first requester after the previous winner, wrapping around
  always_comb begin
    w_win   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req[(int'(r_last) + k) % NREQ]) begin
        w_win   = IDW'((int'(r_last) + k) % NREQ);
        w_found = 1'b1;
      end
    end
  end

  // a write leaving this cycle still occupies a slot the FIFO has not yet counted
  assign w_issue = (|req) && (int'(fifo_free) >= RPJ + int'(f_wr));

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_wrdata && (r_cnt != CNTW'(RPJ + 1))) w_cnt_next = r_cnt + CNTW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= IDW'(NREQ - 1);
      r_id    <= '0;
      r_cnt   <= '0;
      ack     <= '0;
      fin     <= '0;
      w_start <= 1'b0;
      w_ui    <= '0;
      w_vi    <= '0;
      f_wr    <= 1'b0;
      f_data  <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ack     <= '0;
      fin     <= '0;
      w_start <= 1'b0;
      f_wr    <= 1'b0;

      if (w_wrdata) begin
        if (r_state == S_RUN) begin
          f_wr   <= 1'b1;
          f_data <= {r_id, w_data};
        end else begin
          err <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_id    <= w_win;
            r_last  <= w_win;
            w_ui    <= ui_in[2*w_win +: 2];
            w_vi    <= vi_in[16*w_win +: 16];
            r_cnt   <= '0;
            ack     <= ONE_HOT0 << w_win;
            w_start <= 1'b1;
            busy    <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: r_state <= S_RUN;
        S_RUN: begin
          r_cnt <= w_cnt_next;
          if (w_done) begin
            if (w_cnt_next != CNTW'(RPJ)) err <= 1'b1;
            fin     <= ONE_HOT0 << r_id;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
